// File: rtl/fifo_buffer_pkg.sv
// Shared helpers for the fifo_buffer slice: width functions
// and handshake constants.
package fifo_buffer_pkg;

  localparam logic HS_IDLE = 1'b0;
  localparam logic HS_FIRE = 1'b1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic fire(input logic v, input logic r);
    return (v & r) ? HS_FIRE : HS_IDLE;
  endfunction

endpackage

// File: rtl/fifo_buffer_mem.sv
// DEPTH x WIDTH register array for fifo_buffer.
// Synchronous write, asynchronous read, no reset.
module fifo_buffer_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_buffer.sv
// Synchronous show-ahead FIFO with valid/ready on both sides.
// FIFO_BUFFER_PEAK_EN adds a high-watermark register (peak, peak_clr).
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
`ifdef FIFO_BUFFER_PEAK_EN
  ,
  input  logic                       peak_clr,
  output logic [$clog2(DEPTH+1)-1:0] peak
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  ptr_t          wr_ptr_q, wr_ptr_d;
  ptr_t          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty;
  logic          push, pop;

  // Extra pointer MSB separates full from empty on equal low bits.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
            (wr_ptr_q[AW] != rd_ptr_q[AW]);
    push  = fire(in_valid, !full);
    pop   = fire(!empty, out_ready);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    unique case (1'b1)
      (push && !pop): count_d = count_q + CW'(1);
      (pop && !push): count_d = count_q - CW'(1);
      default:        count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (out_data)
  );

  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AF_LEVEL));

`ifdef FIFO_BUFFER_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  // Clear loads the pre-edge count; a same-cycle change lands next cycle.
  always_comb begin
    peak_d = peak_q;
    if (peak_clr) begin
      peak_d = count_q;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`endif

endmodule
